// File: rtl/id_stage_dual_pkg.sv
// Shared types, opcode constants and decode/control/hazard helpers for the
// dual-issue RV32I decode stage.
package id_stage_dual_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    NONE_c, REG_WRITE, MEM_READ, MEM_WRITE, ALU_REG, ALU_IMM, BRANCH, JAL, JALR
  } ctrl_t;

  typedef enum logic [2:0] {
    NONE_h, EX_MEM_A, EX_MEM_B, MEM_WB_A, MEM_WB_B, B_DEP_A, STALL_LOAD
  } haz_e;

  typedef struct packed {
    logic [6:0]      funct7;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rs1;
    logic [2:0]      funct3;
    logic [RW-1:0]   rd;
    logic [6:0]      op;
    logic [XLEN-1:0] imm;
  } id_t;

  typedef struct packed { id_t A; id_t B; } id_ex_t;

  typedef struct packed {
    ctrl_t wb;
    ctrl_t mem;
    ctrl_t alu;
    ctrl_t target;
  } lane_ctrl_t;

  typedef struct packed { lane_ctrl_t A; lane_ctrl_t B; } ctrl_N_t;

  // Destination register plus its write-back control, as carried by a pipe lane.
  typedef struct packed { logic [RW-1:0] rd; ctrl_t wb; } wb_t;
  typedef struct packed { wb_t A; wb_t B; } rd_ctrl_N_t;

  typedef struct packed { haz_e ForwA; haz_e ForwB; } lane_haz_t;
  typedef struct packed { lane_haz_t A; lane_haz_t B; } haz_t;

  typedef struct packed { logic [XLEN-1:0] A; logic [XLEN-1:0] B; } reg_pair_t;
  typedef struct packed { reg_pair_t one; reg_pair_t two; } regs_t;

  typedef struct packed { wb_t dst; logic [XLEN-1:0] data; } wr_port_t;

  function automatic id_t decode(input logic [XLEN-1:0] i);
    id_t d;
    d.op     = i[6:0];
    d.rd     = i[11:7];
    d.funct3 = i[14:12];
    d.rs1    = i[19:15];
    d.rs2    = i[24:20];
    d.funct7 = i[31:25];
    case (i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: d.imm = {{20{i[31]}}, i[31:20]};
      OPC_STORE:          d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OPC_BRANCH:         d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: d.imm = {i[31:12], 12'b0};
      OPC_JAL:            d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default:            d.imm = '0;
    endcase
    return d;
  endfunction

  function automatic lane_ctrl_t control(input logic [6:0] op);
    lane_ctrl_t c;
    c = '{wb: NONE_c, mem: NONE_c, alu: NONE_c, target: NONE_c};
    case (op)
      OPC_OP:     begin c.wb = REG_WRITE; c.alu = ALU_REG; end
      OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin c.wb = REG_WRITE; c.alu = ALU_IMM; end
      OPC_LOAD:   begin c.wb = REG_WRITE; c.mem = MEM_READ; c.alu = ALU_IMM; end
      OPC_STORE:  begin c.mem = MEM_WRITE; c.alu = ALU_IMM; end
      OPC_BRANCH: begin c.alu = ALU_IMM; c.target = BRANCH; end
      OPC_JAL:    begin c.wb = REG_WRITE; c.alu = ALU_IMM; c.target = JAL; end
      OPC_JALR:   begin c.wb = REG_WRITE; c.alu = ALU_IMM; c.target = JALR; end
      default:    ;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OPC_OP) || (op == OPC_OP_IMM) || (op == OPC_LOAD) ||
           (op == OPC_STORE) || (op == OPC_BRANCH) || (op == OPC_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
  endfunction

  function automatic logic src_hit(input wb_t s, input logic [RW-1:0] r);
    return (s.wb == REG_WRITE) && (s.rd != '0) && (s.rd == r);
  endfunction

  function automatic logic load_hit(input id_t d, input logic [RW-1:0] r);
    return (d.op == OPC_LOAD) && (d.rd != '0) && (d.rd == r);
  endfunction

  // Highest-priority producer of operand r; older lane A only counts for lane B.
  function automatic haz_e operand_haz(input logic [RW-1:0] r, input logic used,
                                       input logic lane_b, input wb_t older,
                                       input id_ex_t idex, input rd_ctrl_N_t ex,
                                       input rd_ctrl_N_t mw);
    haz_e h;
    h = NONE_h;
    if (!used)                                         h = NONE_h;
    else if (lane_b && src_hit(older, r))              h = B_DEP_A;
    else if (load_hit(idex.A, r) || load_hit(idex.B, r)) h = STALL_LOAD;
    else if (src_hit(ex.B, r))                         h = EX_MEM_B;
    else if (src_hit(ex.A, r))                         h = EX_MEM_A;
    else if (src_hit(mw.B, r))                         h = MEM_WB_B;
    else if (src_hit(mw.A, r))                         h = MEM_WB_A;
    return h;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two write ports (port 1 wins on collision), four
// combinational write-first read ports, x0 hardwired to zero.
module register_file
  import id_stage_dual_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  wr_port_t      wp1,
  input  wr_port_t      wp2,
  input  logic [RW-1:0] ra_a1,
  input  logic [RW-1:0] ra_a2,
  input  logic [RW-1:0] ra_b1,
  input  logic [RW-1:0] ra_b2,
  output regs_t         rdata
);

  logic [XLEN-1:0] mem [NREGS];
  logic            w1_c;
  logic            w2_c;

  assign w1_c = !rst && (wp1.dst.wb == REG_WRITE) && (wp1.dst.rd != '0);
  assign w2_c = !rst && (wp2.dst.wb == REG_WRITE) && (wp2.dst.rd != '0);

  // Port 1 is written last so lane A's data survives a same-rd collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else begin
      if (w2_c) mem[wp2.dst.rd] <= wp2.data;
      if (w1_c) mem[wp1.dst.rd] <= wp1.data;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [RW-1:0] a,
                                              input logic [XLEN-1:0] stored,
                                              input logic w1, input logic w2,
                                              input wr_port_t p1, input wr_port_t p2);
    if (a == '0)               return '0;
    if (w1 && (p1.dst.rd == a)) return p1.data;
    if (w2 && (p2.dst.rd == a)) return p2.data;
    return stored;
  endfunction

  assign rdata.one.A = rd_port(ra_a1, mem[ra_a1], w1_c, w2_c, wp1, wp2);
  assign rdata.one.B = rd_port(ra_a2, mem[ra_a2], w1_c, w2_c, wp1, wp2);
  assign rdata.two.A = rd_port(ra_b1, mem[ra_b1], w1_c, w2_c, wp1, wp2);
  assign rdata.two.B = rd_port(ra_b2, mem[ra_b2], w1_c, w2_c, wp1, wp2);

endmodule

// File: rtl/id_stage_dual.sv
// Dual-lane decode stage: combinational decode, control and hazard detection
// around a shared two-write register file.
module id_stage_dual
  import id_stage_dual_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr1,
  input  logic [XLEN-1:0] instr2,
  input  id_ex_t          ID_EX,
  input  logic [RW-1:0]   ex_rd1,
  input  logic [RW-1:0]   ex_rd2,
  input  ctrl_t           ex_c1,
  input  ctrl_t           ex_c2,
  input  logic [RW-1:0]   m_rd1,
  input  logic [RW-1:0]   m_rd2,
  input  ctrl_t           m_c1,
  input  ctrl_t           m_c2,
  input  logic [RW-1:0]   rd1,
  input  logic [RW-1:0]   rd2,
  input  logic [XLEN-1:0] wb_data1,
  input  logic [XLEN-1:0] wb_data2,
  input  ctrl_t           wb_we1,
  input  ctrl_t           wb_we2,
  output id_ex_t          ID_out,
  output ctrl_N_t         cntrl,
  output haz_t            haz,
  output regs_t           datas
);

  id_t        dec_a;
  id_t        dec_b;
  lane_ctrl_t ctl_a;
  lane_ctrl_t ctl_b;
  wb_t        a_src;
  rd_ctrl_N_t ex_src;
  rd_ctrl_N_t mw_src;
  wr_port_t   wp1;
  wr_port_t   wp2;

  assign dec_a = decode(instr1);
  assign dec_b = decode(instr2);
  assign ctl_a = control(dec_a.op);
  assign ctl_b = control(dec_b.op);

  assign ID_out.A = dec_a;
  assign ID_out.B = dec_b;
  assign cntrl.A  = ctl_a;
  assign cntrl.B  = ctl_b;

  assign a_src  = '{rd: dec_a.rd, wb: ctl_a.wb};
  assign ex_src = '{A: '{rd: ex_rd1, wb: ex_c1}, B: '{rd: ex_rd2, wb: ex_c2}};
  assign mw_src = '{A: '{rd: m_rd1, wb: m_c1}, B: '{rd: m_rd2, wb: m_c2}};

  // Lane B additionally checks against the older lane A in the same bundle.
  assign haz.A.ForwA = operand_haz(dec_a.rs1, uses_rs1(dec_a.op), 1'b0, a_src, ID_EX, ex_src, mw_src);
  assign haz.A.ForwB = operand_haz(dec_a.rs2, uses_rs2(dec_a.op), 1'b0, a_src, ID_EX, ex_src, mw_src);
  assign haz.B.ForwA = operand_haz(dec_b.rs1, uses_rs1(dec_b.op), 1'b1, a_src, ID_EX, ex_src, mw_src);
  assign haz.B.ForwB = operand_haz(dec_b.rs2, uses_rs2(dec_b.op), 1'b1, a_src, ID_EX, ex_src, mw_src);

  assign wp1 = '{dst: '{rd: rd1, wb: wb_we1}, data: wb_data1};
  assign wp2 = '{dst: '{rd: rd2, wb: wb_we2}, data: wb_data2};

  register_file u_rf (
    .clk   (clk),
    .rst   (rst),
    .wp1   (wp1),
    .wp2   (wp2),
    .ra_a1 (dec_a.rs1),
    .ra_a2 (dec_a.rs2),
    .ra_b1 (dec_b.rs1),
    .ra_b2 (dec_b.rs2),
    .rdata (datas)
  );

endmodule

// File: tb/tb_id_stage_dual.sv
// Bench for id_stage_dual: behavioural model checked every cycle plus
// hand-computed directed expectations.
module tb_id_stage_dual;
  import id_stage_dual_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr1, instr2;
  id_ex_t      ID_EX;
  logic [4:0]  ex_rd1, ex_rd2, m_rd1, m_rd2, rd1, rd2;
  ctrl_t       ex_c1, ex_c2, m_c1, m_c2, wb_we1, wb_we2;
  logic [31:0] wb_data1, wb_data2;
  id_ex_t      ID_out;
  ctrl_N_t     cntrl;
  haz_t        haz;
  regs_t       datas;

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;
  logic [31:0] m_regs [32];

  always #5 clk = ~clk;

  id_stage_dual dut (
    .clk(clk), .rst(rst), .instr1(instr1), .instr2(instr2), .ID_EX(ID_EX),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_c1(ex_c1), .ex_c2(ex_c2),
    .m_rd1(m_rd1), .m_rd2(m_rd2), .m_c1(m_c1), .m_c2(m_c2),
    .rd1(rd1), .rd2(rd2), .wb_data1(wb_data1), .wb_data2(wb_data2),
    .wb_we1(wb_we1), .wb_we2(wb_we2),
    .ID_out(ID_out), .cntrl(cntrl), .haz(haz), .datas(datas)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Instruction class: 0 unknown,1 R,2 I-ALU,3 LOAD,4 STORE,5 BRANCH,6 JAL,7 JALR,8 LUI,9 AUIPC
  function automatic int m_class(input logic [31:0] ins);
    case (ins[6:0])
      7'h33: return 1;
      7'h13: return 2;
      7'h03: return 3;
      7'h23: return 4;
      7'h63: return 5;
      7'h6F: return 6;
      7'h67: return 7;
      7'h37: return 8;
      7'h17: return 9;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_writes(input int c);
    return c inside {1, 2, 3, 6, 7, 8, 9};
  endfunction

  function automatic bit m_uses(input int c, input int operand);
    if (operand == 1) return c inside {1, 2, 3, 4, 5, 7};
    return c inside {1, 4, 5};
  endfunction

  function automatic lane_ctrl_t m_ctrl(input int c);
    lane_ctrl_t k;
    k.wb     = m_writes(c) ? REG_WRITE : NONE_c;
    k.mem    = (c == 3) ? MEM_READ : (c == 4) ? MEM_WRITE : NONE_c;
    k.alu    = (c == 1) ? ALU_REG : (c == 0) ? NONE_c : ALU_IMM;
    k.target = (c == 5) ? BRANCH : (c == 6) ? JAL : (c == 7) ? JALR : NONE_c;
    return k;
  endfunction

  // Fields by shift/mask, immediates as unsigned raw value minus the sign weight.
  function automatic id_t m_dec(input logic [31:0] ins);
    id_t d;
    int unsigned u;
    int sgn, imm;
    u   = ins;
    sgn = int'(u >> 31);
    d.op     = 7'(u & 32'h7F);
    d.rd     = 5'((u >> 7) & 31);
    d.funct3 = 3'((u >> 12) & 7);
    d.rs1    = 5'((u >> 15) & 31);
    d.rs2    = 5'((u >> 20) & 31);
    d.funct7 = 7'(u >> 25);
    case (m_class(ins))
      2, 3, 7: imm = int'((u >> 20) & 32'hFFF) - sgn * 4096;
      4:       imm = int'(((u >> 25) << 5) | ((u >> 7) & 31)) - sgn * 4096;
      5:       imm = int'(((u >> 31) << 12) | (((u >> 7) & 1) << 11) |
                          (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1)) - sgn * 8192;
      6:       imm = int'(((u >> 31) << 20) | (((u >> 12) & 255) << 12) |
                          (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1)) - sgn * (1 << 21);
      8, 9:    imm = int'(u & 32'hFFFFF000);
      default: imm = 0;
    endcase
    d.imm = imm;
    return d;
  endfunction

  // Candidate producers in priority order; first one writing r wins.
  function automatic haz_e m_haz(input logic [4:0] r, input bit used, input bit lane_b);
    logic [4:0] cand_rd [7];
    bit         cand_on [7];
    haz_e       cand_h  [7];
    cand_rd = '{instr1[11:7], ID_EX.A.rd, ID_EX.B.rd, ex_rd2, ex_rd1, m_rd2, m_rd1};
    cand_on = '{lane_b && m_writes(m_class(instr1)), ID_EX.A.op == 7'h03, ID_EX.B.op == 7'h03,
                ex_c2 == REG_WRITE, ex_c1 == REG_WRITE, m_c2 == REG_WRITE, m_c1 == REG_WRITE};
    cand_h  = '{B_DEP_A, STALL_LOAD, STALL_LOAD, EX_MEM_B, EX_MEM_A, MEM_WB_B, MEM_WB_A};
    if (!used) return NONE_h;
    for (int i = 0; i < 7; i++)
      if (cand_on[i] && cand_rd[i] != 5'd0 && cand_rd[i] == r) return cand_h[i];
    return NONE_h;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (!rst && wb_we1 == REG_WRITE && rd1 == r) return wb_data1;
    if (!rst && wb_we2 == REG_WRITE && rd2 == r) return wb_data2;
    return m_regs[r];
  endfunction

  // Architectural register state: clear on reset, port 1 overrides port 2.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else begin
      if (wb_we2 == REG_WRITE && rd2 != 5'd0) m_regs[rd2] = wb_data2;
      if (wb_we1 == REG_WRITE && rd1 != 5'd0) m_regs[rd1] = wb_data1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      id_t da, db;
      int ca, cb;
      ctrl_N_t e_c;
      haz_t e_h;
      regs_t e_d;
      da = m_dec(instr1); db = m_dec(instr2);
      ca = m_class(instr1); cb = m_class(instr2);
      e_c.A = m_ctrl(ca); e_c.B = m_ctrl(cb);
      e_h.A.ForwA = m_haz(da.rs1, m_uses(ca, 1), 1'b0);
      e_h.A.ForwB = m_haz(da.rs2, m_uses(ca, 2), 1'b0);
      e_h.B.ForwA = m_haz(db.rs1, m_uses(cb, 1), 1'b1);
      e_h.B.ForwB = m_haz(db.rs2, m_uses(cb, 2), 1'b1);
      e_d.one.A = m_read(da.rs1); e_d.one.B = m_read(da.rs2);
      e_d.two.A = m_read(db.rs1); e_d.two.B = m_read(db.rs2);
      check("model_id_out", 128'(ID_out), 128'({da, db}));
      check("model_cntrl", 128'(cntrl), 128'(e_c));
      check("model_haz", 128'(haz), 128'(e_h));
      check("model_datas", 128'(datas), 128'(e_d));
    end
  end

  task automatic idle();
    instr1 = 32'h00000013; instr2 = 32'h00000013; ID_EX = '0;
    ex_rd1 = '0; ex_rd2 = '0; m_rd1 = '0; m_rd2 = '0; rd1 = '0; rd2 = '0;
    ex_c1 = NONE_c; ex_c2 = NONE_c; m_c1 = NONE_c; m_c2 = NONE_c;
    wb_we1 = NONE_c; wb_we2 = NONE_c; wb_data1 = '0; wb_data2 = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  logic [31:0] tbl [10];

  initial begin
    tbl = '{32'h002081B3, 32'h00100213, 32'hFF812483, 32'h0051A623, 32'hFE208EE3,
            32'h008000EF, 32'h004300E7, 32'h12345337, 32'hFFFFF397, 32'hFFFFFFFF};
    rst = 1'b1; idle(); instr1 = 32'h002081B3;
    next(); checking = 1'b1;
    @(negedge clk);
    check("rst_read_x1", 128'(datas.one.A), 128'(32'h0));

    next(); rst = 1'b0;
    @(negedge clk);
    check("add_rd", 128'(ID_out.A.rd), 128'(5'd3));
    check("add_rs1", 128'(ID_out.A.rs1), 128'(5'd1));
    check("add_rs2", 128'(ID_out.A.rs2), 128'(5'd2));
    check("add_wb", 128'(cntrl.A.wb), 128'(REG_WRITE));
    check("add_alu", 128'(cntrl.A.alu), 128'(ALU_REG));
    check("add_mem", 128'(cntrl.A.mem), 128'(NONE_c));

    next(); rd1 = 5'd5; wb_data1 = 32'hDEADBEEF; wb_we1 = REG_WRITE; instr1 = 32'h000281B3;
    @(negedge clk); check("bypass_x5", 128'(datas.one.A), 128'(32'hDEADBEEF));
    next(); wb_we1 = NONE_c; wb_data1 = '0;
    @(negedge clk); check("persist_x5", 128'(datas.one.A), 128'(32'hDEADBEEF));

    next(); rd1 = 5'd7; rd2 = 5'd7; wb_data1 = 32'h11; wb_data2 = 32'h22;
    wb_we1 = REG_WRITE; wb_we2 = REG_WRITE; instr1 = 32'h000381B3;
    @(negedge clk); check("collide_bypass_x7", 128'(datas.one.A), 128'(32'h11));
    next(); wb_we1 = NONE_c; wb_we2 = NONE_c;
    @(negedge clk); check("collide_store_x7", 128'(datas.one.A), 128'(32'h11));

    next(); idle(); instr1 = 32'h00100213; instr2 = 32'h000202B3; ex_rd1 = 5'd1; ex_c1 = REG_WRITE;
    @(negedge clk);
    check("b_dep_a", 128'(haz.B.ForwA), 128'(B_DEP_A));
    check("itype_rs2_unused", 128'(haz.A.ForwB), 128'(NONE_h));

    next(); idle(); ex_rd1 = 5'd6; ex_c1 = REG_WRITE; m_rd2 = 5'd6; m_c2 = REG_WRITE; instr1 = 32'h000301B3;
    @(negedge clk); check("ex_mem_a", 128'(haz.A.ForwA), 128'(EX_MEM_A));
    next(); ex_c1 = NONE_c;
    @(negedge clk); check("mem_wb_b", 128'(haz.A.ForwA), 128'(MEM_WB_B));
    next(); ex_c1 = REG_WRITE; ex_rd2 = 5'd6; ex_c2 = REG_WRITE;
    @(negedge clk); check("ex_mem_b_first", 128'(haz.A.ForwA), 128'(EX_MEM_B));

    next(); idle(); ID_EX.A.op = 7'h03; ID_EX.A.rd = 5'd9; ex_rd1 = 5'd9; ex_c1 = REG_WRITE; instr1 = 32'h000481B3;
    @(negedge clk); check("stall_load", 128'(haz.A.ForwA), 128'(STALL_LOAD));
    next(); idle(); ex_c1 = REG_WRITE; m_c1 = REG_WRITE; ID_EX.A.op = 7'h03; instr1 = 32'h000001B3;
    @(negedge clk); check("rd0_no_haz", 128'(haz.A), 128'({NONE_h, NONE_h}));
    next(); idle(); instr1 = 32'h00100213; instr2 = 32'h000202B3; ID_EX.B.op = 7'h03; ID_EX.B.rd = 5'd4;
    @(negedge clk); check("b_dep_over_stall", 128'(haz.B.ForwA), 128'(B_DEP_A));
    next(); idle(); instr1 = 32'h000301B7; ex_rd1 = 5'd6; ex_c1 = REG_WRITE;
    @(negedge clk); check("lui_rs1_unused", 128'(haz.A.ForwA), 128'(NONE_h));

    next(); idle(); instr1 = 32'hFFFFFFFF;
    @(negedge clk);
    check("unknown_ctrl", 128'(cntrl.A), 128'({NONE_c, NONE_c, NONE_c, NONE_c}));
    check("unknown_rs1", 128'(ID_out.A.rs1), 128'(5'd31));
    next(); instr1 = 32'hFE208EE3; instr2 = 32'hFF812483;
    @(negedge clk);
    check("beq_imm", 128'(ID_out.A.imm), 128'(32'hFFFFFFFC));
    check("lw_imm", 128'(ID_out.B.imm), 128'(32'hFFFFFFF8));
    next(); instr1 = 32'h0051A623; instr2 = 32'h008000EF;
    @(negedge clk);
    check("sw_imm", 128'(ID_out.A.imm), 128'(32'h0000000C));
    check("jal_imm", 128'(ID_out.B.imm), 128'(32'h00000008));
    next(); instr1 = 32'h12345337; instr2 = 32'hFFFFF397;
    @(negedge clk);
    check("lui_imm", 128'(ID_out.A.imm), 128'(32'h12345000));
    check("auipc_target", 128'(cntrl.B.alu), 128'(ALU_IMM));

    next(); idle(); rd1 = 5'd0; wb_data1 = 32'h55; wb_we1 = REG_WRITE; instr1 = 32'h000001B3;
    @(negedge clk); check("x0_no_bypass", 128'(datas.one.A), 128'(32'h0));
    next(); wb_we1 = NONE_c;
    @(negedge clk); check("x0_stays_zero", 128'(datas.one.A), 128'(32'h0));

    for (int k = 0; k < 40; k++) begin
      next();
      instr1 = tbl[k % 10]; instr2 = tbl[(k * 3 + 1) % 10];
      rd1 = 5'(k % 10); rd2 = 5'((k + 3) % 10);
      wb_data1 = $urandom; wb_data2 = $urandom;
      wb_we1 = (k % 3 != 0) ? REG_WRITE : NONE_c;
      wb_we2 = (k % 2 == 0) ? REG_WRITE : NONE_c;
      ex_rd1 = 5'((k * 7) % 10); ex_c1 = (k % 2 == 1) ? REG_WRITE : NONE_c;
      ex_rd2 = 5'((k * 3) % 10); ex_c2 = (k % 4 == 1) ? REG_WRITE : NONE_c;
      m_rd1 = 5'((k + 2) % 10); m_c1 = REG_WRITE;
      m_rd2 = 5'((k * 5) % 10); m_c2 = (k % 3 == 1) ? REG_WRITE : NONE_c;
      ID_EX.A.op = (k % 4 == 0) ? 7'h03 : 7'h33; ID_EX.A.rd = 5'((k * 9) % 10);
      ID_EX.B.op = (k % 5 == 0) ? 7'h03 : 7'h13; ID_EX.B.rd = 5'((k * 4) % 10);
    end

    next(); idle(); rst = 1'b1;
    next(); rst = 1'b0; instr1 = 32'h007281B3;
    @(negedge clk);
    check("post_rst_x5", 128'(datas.one.A), 128'(32'h0));
    check("post_rst_x7", 128'(datas.one.B), 128'(32'h0));

    next(); checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
